// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//
// Issue/completion controller for the shared iterative multiply/divide unit.
// A MUL or DIV seen in the X stage is accepted from IDLE. The unit is started
// with a one-cycle ctrl_mult/ctrl_div pulse, and the pipeline is stalled until
// the unit answers or the timeout fires. The completed result, its destination
// tag and its exception flag are then presented with a one-cycle result_valid
// strobe. Divide-by-zero completes on its own, without starting the unit.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   issue_valid    X-stage instruction valid
//   op, aluop      opcode / ALU op fields used to decode MUL and DIV
//   rd_in          destination register of the X-stage instruction
//   operand_b      divisor, checked for divide-by-zero
//   flush          squash the X-stage instruction or the in-flight operation
//   unit_ready     multdiv unit result ready
//   unit_result    multdiv unit result
//   unit_exception multdiv unit exception (overflow)
//   ctrl_mult      one-cycle start pulse, multiply
//   ctrl_div       one-cycle start pulse, divide
//   stall          hold PC/F/D/X pipeline registers
//   result_valid   one-cycle completion strobe
//   result         completed result (held until the next completion)
//   result_rd      destination tag of the completed result (held)
//   exception      exception flag of the completed result (held)
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [4:0]       op,
  input  logic [4:0]       aluop,
  input  logic [4:0]       rd_in,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             unit_ready,
  input  logic [WIDTH-1:0] unit_result,
  input  logic             unit_exception,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             exception
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0]       OP_RTYPE  = 5'b00000;
  localparam logic [4:0]       ALU_MUL   = 5'b00110;
  localparam logic [4:0]       ALU_DIV   = 5'b00111;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [4:0]       pending_rd;
  logic             is_mul;
  logic             is_div;
  logic             accept;
  logic             div_by_zero;
  logic             first_wait;

  // Decode the X-stage instruction and decide whether it is taken this cycle.
  // Only IDLE can take a new operation, and a flushed instruction is never
  // taken. The first WAIT cycle is the one in which the start pulse is out;
  // the counter is still zero there, so a stale ready from the previous
  // operation can be recognised and ignored.
  always_comb begin
    is_mul      = (op == OP_RTYPE) && (aluop == ALU_MUL);
    is_div      = (op == OP_RTYPE) && (aluop == ALU_DIV);
    accept      = (state == ST_IDLE) && issue_valid && (is_mul || is_div) && !flush;
    div_by_zero = is_div && (operand_b == '0);
    first_wait  = (counter == '0);
  end

  // The pipeline is held while an operation is being taken or is in flight.
  // It is released in DONE so the instruction leaves X together with the
  // strobe, and released at once by a flush. During reset nothing is driven.
  // The strobe is dropped in a flushed cycle because the instruction that
  // owns it is being squashed.
  assign stall        = reset_n && !flush &&
                        (accept || (state == ST_WAIT) || ctrl_mult || ctrl_div);
  assign result_valid = (state == ST_DONE) && !flush;

  // Main controller. Start pulses default low so they last exactly one cycle.
  // A divide-by-zero skips the unit and goes straight to DONE with an
  // exception. In WAIT the counter runs every cycle; a ready from the unit
  // wins over a timeout in the same cycle, and a flush abandons the operation
  // without touching the held result, tag or exception.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      pending_rd <= '0;
      ctrl_mult  <= 1'b0;
      ctrl_div   <= 1'b0;
      result     <= '0;
      result_rd  <= '0;
      exception  <= 1'b0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pending_rd <= rd_in;
            if (div_by_zero) begin
              state     <= ST_DONE;
              result    <= '0;
              result_rd <= rd_in;
              exception <= 1'b1;
            end else begin
              state     <= ST_WAIT;
              counter   <= '0;
              ctrl_mult <= is_mul;
              ctrl_div  <= is_div;
            end
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state   <= ST_IDLE;
            counter <= '0;
          end else if (unit_ready && !first_wait) begin
            state     <= ST_DONE;
            result    <= unit_result;
            result_rd <= pending_rd;
            exception <= unit_exception;
          end else if (counter == LAST_WAIT) begin
            state     <= ST_DONE;
            result    <= '0;
            result_rd <= pending_rd;
            exception <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          counter <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule
